// File: rtl/sync_fifo_param_if.sv
// Handshake/status bundle between a synchronous FIFO and its producer/consumer.
// The master side drives requests; the slave side is the FIFO itself.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              wr;
    logic [DATA_W-1:0] data_in;
    logic              rd;
    logic              err_clr;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [CW-1:0]     fifo_cnt;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr, data_in, rd, err_clr,
        input  data_out, data_valid, empty, full, almost_empty, almost_full,
               fifo_cnt, overflow, underflow
    );

    modport slave (
        input  wr, data_in, rd, err_clr,
        output data_out, data_valid, empty, full, almost_empty, almost_full,
               fifo_cnt, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with threshold flags and sticky overflow/underflow.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is a registered read.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_param_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] AF_T   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_T   = CW'(AE_THRESH);
    localparam logic [CW-1:0] FULL_T = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              overflow_q;
    logic              underflow_q;
    logic              empty_w;
    logic              full_w;
    logic              rd_ok;
    logic              wr_ok;

    // Flags decode from the registered count, so none depend combinationally on rd/wr.
    assign empty_w = (cnt == '0);
    assign full_w  = (cnt == FULL_T);
    assign rd_ok   = bus.rd & ~empty_w;
    assign wr_ok   = bus.wr & (~full_w | rd_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            cnt         <= cnt + CW'(wr_ok) - CW'(rd_ok);
            // A new error in the same cycle as err_clr leaves the flag set.
            overflow_q  <= (overflow_q & ~bus.err_clr) | (bus.wr & ~wr_ok);
            underflow_q <= (underflow_q & ~bus.err_clr) | (bus.rd & ~rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= bus.data_in;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.data_out   = empty_w ? '0 : mem[rd_ptr];
    assign bus.data_valid = ~empty_w;
`else
    logic [DATA_W-1:0] dout_q;
    logic              dv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            dv_q <= rd_ok;
            if (rd_ok) dout_q <= mem[rd_ptr];
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = dv_q;
`endif

    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_empty = (cnt <= AE_T);
    assign bus.almost_full  = (cnt >= AF_T);
    assign bus.fifo_cnt     = cnt;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: queue-based reference model checked every cycle,
// directed boundary scenarios with literal expectations, then randomized traffic.
module tb_sync_fifo_param;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int AF     = 6;
    localparam int AE     = 2;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sync_fifo_param #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, plus last popped word and sticky errors.
    int   mq[$];
    int   m_dout;
    bit   m_dv, m_ovf, m_udf;
    bit   can_rd, can_wr;
    int   n;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_dout = 0;
            m_dv   = 0;
            m_ovf  = 0;
            m_udf  = 0;
        end else begin
            can_rd = bus.rd && (mq.size() > 0);
            can_wr = bus.wr && ((mq.size() < DEPTH) || can_rd);
            m_dv   = can_rd;
            if (can_rd) m_dout = mq.pop_front();
            if (can_wr) mq.push_back(int'(bus.data_in));
            m_ovf = (m_ovf && !bus.err_clr) || (bus.wr && !can_wr);
            m_udf = (m_udf && !bus.err_clr) || (bus.rd && !can_rd);
        end
    end

    always @(negedge clk) begin
        n = mq.size();
        check("fifo_cnt", int'(bus.fifo_cnt), n);
        check("empty", int'(bus.empty), int'(n == 0));
        check("full", int'(bus.full), int'(n == DEPTH));
        check("almost_empty", int'(bus.almost_empty), int'(n <= AE));
        check("almost_full", int'(bus.almost_full), int'(n >= AF));
        check("overflow", int'(bus.overflow), int'(m_ovf));
        check("underflow", int'(bus.underflow), int'(m_udf));
`ifdef SYNC_FIFO_FWFT_EN
        check("data_out", int'(bus.data_out), (n > 0) ? mq[0] : 0);
        check("data_valid", int'(bus.data_valid), int'(n > 0));
`else
        check("data_out", int'(bus.data_out), m_dout);
        check("data_valid", int'(bus.data_valid), int'(m_dv));
`endif
    end

    // Drive one cycle's inputs just after a falling edge; return at the next falling edge.
    task automatic cyc(input bit w, input int d, input bit r, input bit c, input bit rs);
        bus.wr      = w;
        bus.data_in = DATA_W'(d);
        bus.rd      = r;
        bus.err_clr = c;
        rst         = rs;
        @(negedge clk);
    endtask

    task automatic rd_expect(input string name, input int exp);
`ifdef SYNC_FIFO_FWFT_EN
        check({name, "_dout"}, int'(bus.data_out), exp);
        check({name, "_dv"}, int'(bus.data_valid), 1);
        cyc(0, 0, 1, 0, 0);
`else
        cyc(0, 0, 1, 0, 0);
        check({name, "_dout"}, int'(bus.data_out), exp);
        check({name, "_dv"}, int'(bus.data_valid), 1);
`endif
    endtask

    int pw, pr;
    int exp5[8];

    initial begin
        bus.wr = 0; bus.data_in = '0; bus.rd = 0; bus.err_clr = 0; rst = 1;

        // 1: reset
        @(negedge clk);
        cyc(0, 0, 0, 0, 1);
        check("rst_cnt", int'(bus.fifo_cnt), 0);
        check("rst_empty", int'(bus.empty), 1);
        check("rst_full", int'(bus.full), 0);
        check("rst_ae", int'(bus.almost_empty), 1);
        check("rst_af", int'(bus.almost_full), 0);
        check("rst_dout", int'(bus.data_out), 0);
        check("rst_dv", int'(bus.data_valid), 0);
        check("rst_ovf", int'(bus.overflow), 0);
        check("rst_udf", int'(bus.underflow), 0);

        // 2: fill and overflow
        for (int i = 1; i <= 10; i++) begin
            cyc(1, i, 0, 0, 0);
            check("fill_cnt", int'(bus.fifo_cnt), (i < 8) ? i : 8);
            check("fill_ae", int'(bus.almost_empty), int'(i < 3));
            check("fill_af", int'(bus.almost_full), int'(i >= 6));
            check("fill_full", int'(bus.full), int'(i >= 8));
            check("fill_ovf", int'(bus.overflow), int'(i >= 9));
        end

        // 3: drain and underflow
        for (int i = 1; i <= 8; i++) rd_expect("drain", i);
        check("drain_empty", int'(bus.empty), 1);
        check("drain_udf0", int'(bus.underflow), 0);
        for (int i = 9; i <= 10; i++) begin
            cyc(0, 0, 1, 0, 0);
            check("udf_set", int'(bus.underflow), 1);
            check("udf_dv", int'(bus.data_valid), 0);
`ifdef SYNC_FIFO_FWFT_EN
            check("udf_dout", int'(bus.data_out), 0);
`else
            check("udf_dout_hold", int'(bus.data_out), 8);
`endif
        end
        cyc(0, 0, 0, 1, 0);
        check("clr_ovf", int'(bus.overflow), 0);
        check("clr_udf", int'(bus.underflow), 0);

        // 4: simultaneous rd/wr at full and at empty
        for (int i = 1; i <= 8; i++) cyc(1, 100 + i, 0, 0, 0);
        cyc(1, 42, 1, 0, 0);
        check("full_rw_cnt", int'(bus.fifo_cnt), 8);
        check("full_rw_ovf", int'(bus.overflow), 0);
        for (int i = 2; i <= 8; i++) rd_expect("full_rw_seq", 100 + i);
        rd_expect("full_rw_last", 42);
        check("full_rw_empty", int'(bus.empty), 1);
        cyc(1, 55, 1, 0, 0);
        check("empty_rw_cnt", int'(bus.fifo_cnt), 1);
        check("empty_rw_udf", int'(bus.underflow), 1);
`ifndef SYNC_FIFO_FWFT_EN
        check("empty_rw_dv", int'(bus.data_valid), 0);
`endif
        rd_expect("empty_rw_next", 55);

        // 5: pointer wrap, then mid-operation reset
        cyc(0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(1, 30, 0, 0, 0);
        for (int i = 0; i < 3; i++) rd_expect("wrap_pre", 30);
        for (int i = 0; i < 6; i++) cyc(1, 87, 0, 0, 0);
        check("wrap_cnt", int'(bus.fifo_cnt), 8);
        exp5 = '{30, 30, 87, 87, 87, 87, 87, 87};
        for (int i = 0; i < 8; i++) rd_expect("wrap_seq", exp5[i]);
        for (int i = 0; i < 4; i++) cyc(1, 30, 0, 0, 0);
        check("pre_rst_cnt", int'(bus.fifo_cnt), 4);
        cyc(1, 30, 0, 0, 1);
        check("mid_rst_cnt", int'(bus.fifo_cnt), 0);
        check("mid_rst_empty", int'(bus.empty), 1);

`ifdef SYNC_FIFO_FWFT_EN
        // 6: first-word-fall-through presentation
        cyc(1, 42, 0, 0, 0);
        check("fwft_dout", int'(bus.data_out), 42);
        check("fwft_dv", int'(bus.data_valid), 1);
        cyc(0, 0, 1, 0, 0);
        check("fwft_pop_empty", int'(bus.empty), 1);
        check("fwft_pop_dv", int'(bus.data_valid), 0);
`endif

        // Randomized traffic with shifting read/write bias to visit both boundaries
        pw = 50; pr = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                pw = int'($urandom_range(15, 90));
                pr = int'($urandom_range(15, 90));
            end
            cyc(($urandom_range(0, 99) < pw), int'($urandom_range(0, 255)),
                ($urandom_range(0, 99) < pr), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 299) == 0));
        end

        cyc(0, 0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised single-clock synchronous FIFO. It is the next generation of the fixed 8-bit FIFO and generalises data width and depth. It adds programmable almost-full/almost-empty thresholds, a read-valid strobe, and sticky overflow/underflow error flags. It sits between producer and consumer logic in the same clock domain.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full asserts when fifo_cnt >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when fifo_cnt <= AE_THRESH (0..DEPTH-1)
Derived: AW = $clog2(DEPTH); CW = AW+1

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
wr  input  1  write request
data_in  input  DATA_W  write data, sampled with wr
rd  input  1  read request
data_out  output  DATA_W  read data
data_valid  output  1  data_out holds a freshly popped word this cycle
empty  output  1  fifo_cnt == 0
full  output  1  fifo_cnt == DEPTH
almost_empty  output  1  fifo_cnt <= AE_THRESH
almost_full  output  1  fifo_cnt >= AF_THRESH
fifo_cnt  output  CW  current occupancy, 0..DEPTH
overflow  output  1  sticky: a write was dropped
underflow  output  1  sticky: a read was ignored
err_clr  input  1  clears overflow and underflow

Behaviour:
- Reset (rst=1 at posedge): wr_ptr=rd_ptr=0; fifo_cnt=0; data_out=0; data_valid=0; overflow=underflow=0; empty=1; full=0; almost_empty=1; almost_full=(AF_THRESH==0 ? 1 : 0). Memory contents are not cleared. Reset mid-operation discards all stored data. Reset has priority over all other inputs.
- Accept rules, evaluated per cycle:
  - wr_ok = wr & (~full | rd_ok)
  - rd_ok = rd & ~empty
- Write: when wr_ok, mem[wr_ptr] <= data_in and wr_ptr increments, wrapping DEPTH-1 -> 0.
- Read: when rd_ok, data_out <= mem[rd_ptr] and rd_ptr increments with wrap. Read latency is 1 cycle: data_valid=1 in the cycle after rd_ok, otherwise 0. data_out holds its last value when no read occurs.
- Count: fifo_cnt += wr_ok - rd_ok. Simultaneous accepted read and write leaves the count unchanged.
- Full with rd & wr: both are accepted and the count stays at DEPTH.
- Empty with rd & wr: the write is accepted and the read is ignored. Underflow is set. There is no bypass; the written word is readable from the next cycle.
- wr while full and no rd: data is dropped and overflow <= 1.
- rd while empty: ignored, underflow <= 1, and data_out is unchanged.
- Error flags: once set, a flag stays set until err_clr or rst. If err_clr and a new error occur in the same cycle, the flag ends up set (set wins).
- Status flags: empty, full, almost_empty and almost_full are registered, or equivalently decoded from the registered fifo_cnt. All four reflect the post-edge count; there is no combinational path from rd or wr.
- Arithmetic: pointers are AW bits and wrap naturally. fifo_cnt is CW bits and never exceeds DEPTH.

Optional Feature:
Macro: SYNC_FIFO_FWFT_EN

With the macro defined, first-word-fall-through mode is used:
- data_out continuously shows mem[rd_ptr] whenever ~empty.
- data_valid = ~empty.
- rd acts as a pop/acknowledge of the presented word.
- A word written into an empty FIFO appears on data_out one cycle after the write edge.
- data_out is 0 while empty.

Without the macro, the standard mode is used: registered read with 1-cycle latency as described above. Flag, count and error behaviour are identical in both modes.

Test Plan:
All scenarios use DATA_W=8, DEPTH=8, AF_THRESH=6, AE_THRESH=2.
1. Reset: rst=1 for 2 cycles -> fifo_cnt=0, empty=1, full=0, almost_empty=1, data_out=0, data_valid=0, overflow=underflow=0.
2. Fill and overflow: wr=1 with data 1..10 for 10 cycles -> almost_empty drops after the 3rd edge; almost_full rises after the 6th edge; full=1 and fifo_cnt=8 after the 8th edge; overflow=1 after the 9th edge; contents are 1..8.
3. Drain and underflow: from full, rd=1 for 10 cycles -> data_out sequence is 1..8, each with data_valid=1 one cycle after its rd; empty=1 after the 8th edge; underflow=1 after the 9th edge; err_clr=1 for one cycle -> both error flags are 0.
4. Simultaneous at boundaries: when full, rd=wr=1 with data 42 -> fifo_cnt stays 8 and 42 is read last. When empty, rd=wr=1 with data 55 -> fifo_cnt=1, underflow=1, and the next read returns 55.
5. Wrap and mid-operation reset: write 30 five times, read three times, then write 87 six times (pointers wrap) -> fifo_cnt=8 and reads return 30,30,87×6. Repeat, but assert rst after 4 writes -> fifo_cnt=0 and empty=1 on the next cycle.
6. SYNC_FIFO_FWFT_EN build: write 42 into an empty FIFO -> data_out=42 and data_valid=1 one cycle after the write edge, with no rd required; a single rd pops it, giving empty=1.
